// File: rtl/serial_byte_queue_pkg.sv
// Shared defaults and width helpers for the serial byte queue.
package serial_byte_queue_pkg;

  localparam int unsigned DEF_WIDTH      = 8;
  localparam int unsigned DEF_DEPTH      = 8;
  localparam int unsigned DEF_BIT_PERIOD = 100;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int unsigned DEF_PTR_W = ptr_width(DEF_DEPTH);
  localparam int unsigned DEF_CNT_W = DEF_PTR_W + 1;

endpackage

// File: rtl/serial_byte_queue_fifo.sv
// Synchronous byte FIFO with a registered read port; a pop on empty leaves o_dout unchanged.
module byte_fifo
  import serial_byte_queue_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_dout;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_dout    = r_dout;
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_dout   <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop) begin
        r_dout   <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/serial_byte_queue.sv
// Mid-bit serial deserializer (MSB first) feeding a byte FIFO; dequeue_in rising edges pop to data_out.
module serial_byte_queue
  import serial_byte_queue_pkg::*;
#(
  parameter int unsigned BIT_PERIOD = DEF_BIT_PERIOD,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned WIDTH      = DEF_WIDTH
) (
  input  logic             clock1M,
  input  logic             reset,
  input  logic             data_in,
  input  logic             write_in,
  input  logic             dequeue_in,
  output logic [WIDTH-1:0] data_out,
  output logic             status_out
);

  localparam int unsigned PH_W = $clog2(BIT_PERIOD);
  localparam int unsigned BC_W = $clog2(WIDTH);
  localparam logic [PH_W-1:0] PH_MID  = PH_W'(BIT_PERIOD / 2);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(BIT_PERIOD - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(WIDTH - 1);

  logic [PH_W-1:0]  r_phase;
  logic [BC_W-1:0]  r_bitcnt;
  logic [WIDTH-1:0] r_sr;
  logic             r_pending;
  logic             r_status;
  logic             r_deq_q;

  logic             w_sample;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;

  // A pending byte lives in r_sr, so sampling stalls until the FIFO accepts it.
  assign w_sample   = write_in & (r_phase == PH_MID) & ~r_pending;
  assign w_push     = r_pending & ~w_full;
  assign w_pop      = dequeue_in & ~r_deq_q & ~w_empty;
  assign status_out = r_status;

  always_ff @(posedge clock1M or negedge reset) begin
    if (!reset) begin
      r_phase   <= '0;
      r_bitcnt  <= '0;
      r_sr      <= '0;
      r_pending <= 1'b0;
      r_status  <= 1'b0;
      r_deq_q   <= 1'b0;
    end else begin
      r_deq_q  <= dequeue_in;
      r_status <= (r_bitcnt != '0) | r_pending;

      // Holding phase at 0 while idle makes the write_in rising edge the phase origin.
      if (!write_in || r_phase == PH_LAST) r_phase <= '0;
      else                                 r_phase <= r_phase + 1'b1;

      if (!write_in) begin
        r_bitcnt <= '0;
      end else if (w_sample) begin
        r_sr <= {r_sr[WIDTH-2:0], data_in};
        if (r_bitcnt == BC_LAST) begin
          r_bitcnt  <= '0;
          r_pending <= 1'b1;
        end else begin
          r_bitcnt <= r_bitcnt + 1'b1;
        end
      end

      if (w_push) r_pending <= 1'b0;
    end
  end

  byte_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clock1M),
    .i_rst_n (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (r_sr),
    .o_dout  (data_out),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule

// File: tb/tb_serial_byte_queue.sv
// Bench for serial_byte_queue: directed vector table, corner sequences, random ops vs a byte-queue model.
module tb_serial_byte_queue;

  logic       clock1M;
  logic       reset;
  logic       data_in;
  logic       write_in;
  logic       dequeue_in;
  logic [7:0] data_out;
  logic       status_out;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  serial_byte_queue #(
    .BIT_PERIOD (100),
    .DEPTH      (8),
    .WIDTH      (8)
  ) dut (
    .clock1M    (clock1M),
    .reset      (reset),
    .data_in    (data_in),
    .write_in   (write_in),
    .dequeue_in (dequeue_in),
    .data_out   (data_out),
    .status_out (status_out)
  );

  initial clock1M = 1'b0;
  always #5 clock1M = ~clock1M;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  typedef enum int unsigned {OP_SEND, OP_DEQ, OP_ABORT} op_e;
  typedef struct {
    op_e        op;
    logic [7:0] val;
    logic [7:0] exp_dout;
    logic       exp_status;
  } vec_t;

  vec_t tbl [17];

  logic [7:0] mq [$];
  logic       m_pend;
  logic [7:0] m_pval;
  logic [7:0] m_dout;

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clock1M);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at time %0t", name, act, exp, $time);
    end
  endtask

  task automatic send_bits(input logic [7:0] val, input int unsigned nbits);
    write_in = 1'b1;
    for (int unsigned i = 0; i < nbits; i++) begin
      data_in = val[3'(7 - i)];
      tick(100);
      if (i == 3) check("busy_mid_session", {31'd0, status_out}, 32'd1);
    end
    write_in = 1'b0;
    data_in  = 1'b0;
    tick(5);
  endtask

  task automatic deq_pulse(input int unsigned len);
    dequeue_in = 1'b1;
    tick(len);
    dequeue_in = 1'b0;
    tick(4);
  endtask

  task automatic model_send(input logic [7:0] v);
    if (!m_pend) begin
      if (mq.size() < 8) mq.push_back(v);
      else begin
        m_pend = 1'b1;
        m_pval = v;
      end
    end
  endtask

  task automatic model_deq();
    if (mq.size() > 0) begin
      m_dout = mq.pop_front();
      if (m_pend) begin
        mq.push_back(m_pval);
        m_pend = 1'b0;
      end
    end
  endtask

  logic [7:0] full_bytes [9];
  logic [7:0] rv;
  int unsigned sel;

  initial begin
    tbl[0]  = '{OP_DEQ,   8'h00, 8'h00, 1'b0};
    tbl[1]  = '{OP_SEND,  8'hAA, 8'h00, 1'b0};
    tbl[2]  = '{OP_DEQ,   8'h00, 8'hAA, 1'b0};
    tbl[3]  = '{OP_DEQ,   8'h00, 8'hAA, 1'b0};
    tbl[4]  = '{OP_SEND,  8'hCC, 8'hAA, 1'b0};
    tbl[5]  = '{OP_SEND,  8'hF0, 8'hAA, 1'b0};
    tbl[6]  = '{OP_SEND,  8'h0F, 8'hAA, 1'b0};
    tbl[7]  = '{OP_SEND,  8'h33, 8'hAA, 1'b0};
    tbl[8]  = '{OP_DEQ,   8'h00, 8'hCC, 1'b0};
    tbl[9]  = '{OP_DEQ,   8'h00, 8'hF0, 1'b0};
    tbl[10] = '{OP_DEQ,   8'h00, 8'h0F, 1'b0};
    tbl[11] = '{OP_DEQ,   8'h00, 8'h33, 1'b0};
    tbl[12] = '{OP_ABORT, 8'hE0, 8'h33, 1'b0};
    tbl[13] = '{OP_DEQ,   8'h00, 8'h33, 1'b0};
    tbl[14] = '{OP_SEND,  8'h00, 8'h33, 1'b0};
    tbl[15] = '{OP_DEQ,   8'h00, 8'h00, 1'b0};
    tbl[16] = '{OP_DEQ,   8'h00, 8'h00, 1'b0};

    full_bytes = '{8'h55, 8'h99, 8'hFF, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};

    reset      = 1'b0;
    data_in    = 1'b0;
    write_in   = 1'b0;
    dequeue_in = 1'b0;
    tick(100);
    #2 reset = 1'b1;
    tick(2);
    check("reset_dout",   {24'd0, data_out},   32'h00);
    check("reset_status", {31'd0, status_out}, 32'd0);

    for (int unsigned i = 0; i < 17; i++) begin
      case (tbl[i].op)
        OP_SEND:  send_bits(tbl[i].val, 8);
        OP_ABORT: send_bits(tbl[i].val, 3);
        default:  deq_pulse(100);
      endcase
      check($sformatf("vec%0d_dout", i),   {24'd0, data_out},   {24'd0, tbl[i].exp_dout});
      check($sformatf("vec%0d_status", i), {31'd0, status_out}, {31'd0, tbl[i].exp_status});
    end

    for (int unsigned i = 0; i < 9; i++) send_bits(full_bytes[i], 8);
    check("full_pending_status", {31'd0, status_out}, 32'd1);
    tick(300);
    check("full_pending_hold", {31'd0, status_out}, 32'd1);
    deq_pulse(100);
    check("full_first_pop", {24'd0, data_out},   32'h55);
    check("full_pend_enter", {31'd0, status_out}, 32'd0);
    for (int unsigned i = 1; i < 9; i++) begin
      deq_pulse(100);
      check($sformatf("full_drain%0d", i), {24'd0, data_out}, {24'd0, full_bytes[i]});
    end
    deq_pulse(100);
    check("full_empty_pop", {24'd0, data_out}, 32'h9A);

    send_bits(8'h3C, 8);
    deq_pulse(20);
    check("pre_reset_pop", {24'd0, data_out}, 32'h3C);
    send_bits(8'h5A, 8);
    write_in = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      data_in = 1'b1;
      tick(100);
    end
    check("pre_reset_busy", {31'd0, status_out}, 32'd1);
    #3 reset = 1'b0;
    #1;
    check("async_reset_dout",   {24'd0, data_out},   32'h00);
    check("async_reset_status", {31'd0, status_out}, 32'd0);
    write_in = 1'b0;
    data_in  = 1'b0;
    tick(5);
    #2 reset = 1'b1;
    tick(3);
    deq_pulse(50);
    check("reset_queue_lost", {24'd0, data_out},   32'h00);
    check("reset_idle",       {31'd0, status_out}, 32'd0);

    mq.delete();
    m_pend = 1'b0;
    m_pval = 8'h00;
    m_dout = 8'h00;
    for (int unsigned n = 0; n < 30; n++) begin
      sel = $urandom_range(0, 99);
      rv  = 8'($urandom);
      if (sel < 55) begin
        send_bits(rv, 8);
        model_send(rv);
      end else if (sel < 85) begin
        deq_pulse($urandom_range(1, 100));
        model_deq();
      end else begin
        send_bits(rv, $urandom_range(1, 7));
      end
      check($sformatf("rand%0d_dout", n),   {24'd0, data_out},   {24'd0, m_dout});
      check($sformatf("rand%0d_status", n), {31'd0, status_out}, {31'd0, m_pend});
    end
    while (mq.size() > 0) begin
      deq_pulse(10);
      model_deq();
      check("rand_drain", {24'd0, data_out}, {24'd0, m_dout});
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
